// File: rtl/mvm_csr_pkg.sv
// mvm_csr_pkg
//   Shared definitions for the MVM CSR slave and anything that drives it:
//   register byte offsets, AXI response codes, the ID constant, config
//   register indices, FSM state types and small decode/merge helpers.
package mvm_csr_pkg;

  // Register byte offsets (address bits [1:0] are ignored by the slave)
  localparam logic [31:0] OFF_CTRL                = 32'h00;
  localparam logic [31:0] OFF_STATUS              = 32'h04;
  localparam logic [31:0] OFF_DAT_IN_BASE         = 32'h08;
  localparam logic [31:0] OFF_DAT_IN_HEAD_STRIDE  = 32'h0C;
  localparam logic [31:0] OFF_DAT_IN_LINE_STRIDE  = 32'h10;
  localparam logic [31:0] OFF_WT_BASE             = 32'h14;
  localparam logic [31:0] OFF_DAT_OUT_BASE        = 32'h18;
  localparam logic [31:0] OFF_DAT_OUT_HEAD_STRIDE = 32'h1C;
  localparam logic [31:0] OFF_DAT_OUT_LINE_STRIDE = 32'h20;
  localparam logic [31:0] OFF_ID                  = 32'h24;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  localparam logic [31:0] MVM_ID = 32'h4D56_4D31;

  // Config register file, indexed from OFF_DAT_IN_BASE in word steps
  localparam int unsigned NUM_CFG                 = 7;
  localparam int unsigned CFG_DAT_IN_BASE         = 0;
  localparam int unsigned CFG_DAT_IN_HEAD_STRIDE  = 1;
  localparam int unsigned CFG_DAT_IN_LINE_STRIDE  = 2;
  localparam int unsigned CFG_WT_BASE             = 3;
  localparam int unsigned CFG_DAT_OUT_BASE        = 4;
  localparam int unsigned CFG_DAT_OUT_HEAD_STRIDE = 5;
  localparam int unsigned CFG_DAT_OUT_LINE_STRIDE = 6;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

  typedef enum logic [2:0] {
    SEL_CTRL,
    SEL_STATUS,
    SEL_CFG,
    SEL_ID,
    SEL_NONE
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] cfg_idx;
  } reg_dec_t;

  // Classify a byte offset; cfg_idx is only meaningful for SEL_CFG
  function automatic reg_dec_t decode_offset(input logic [31:0] off);
    reg_dec_t    dec;
    logic [31:0] off_al;
    off_al      = off & ~32'h3;
    dec.sel     = SEL_NONE;
    dec.cfg_idx = '0;
    if (off_al == OFF_CTRL) begin
      dec.sel = SEL_CTRL;
    end else if (off_al == OFF_STATUS) begin
      dec.sel = SEL_STATUS;
    end else if (off_al >= OFF_DAT_IN_BASE && off_al <= OFF_DAT_OUT_LINE_STRIDE) begin
      dec.sel     = SEL_CFG;
      dec.cfg_idx = 3'((off_al - OFF_DAT_IN_BASE) >> 2);
    end else if (off_al == OFF_ID) begin
      dec.sel = SEL_ID;
    end
    return dec;
  endfunction

  // Byte-lane merge: lanes with strb clear keep their old contents
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mvm_csr_slave.sv
// mvm_csr_slave
//   AXI4-Lite control/status slave for the MVM engine. Holds the engine
//   configuration registers, issues a one-cycle start pulse and tracks
//   busy/done status.
//
//   Ports
//     clk, rst                 single clock, synchronous active-high reset
//     aw*/w*/b*                AXI4-Lite write address/data/response
//     ar*/r*                   AXI4-Lite read address/data
//     start_o                  one-cycle engine start pulse
//     done_i                   one-cycle engine completion pulse
//     cfg_*_o                  config register contents (registered)
module mvm_csr_slave
  import mvm_csr_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,

  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,

  output logic              start_o,
  input  logic              done_i,
  output logic [31:0]       cfg_dat_in_base_o,
  output logic [31:0]       cfg_dat_in_head_stride_o,
  output logic [31:0]       cfg_dat_in_line_stride_o,
  output logic [31:0]       cfg_wt_base_o,
  output logic [31:0]       cfg_dat_out_base_o,
  output logic [31:0]       cfg_dat_out_head_stride_o,
  output logic [31:0]       cfg_dat_out_line_stride_o
);

  wr_state_e wr_state, wr_state_nxt;
  rd_state_e rd_state, rd_state_nxt;

  // Holds the readies low for the reset cycle itself
  logic ready_en;

  logic [ADDR_W-1:0] aw_addr_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;

  logic [31:0] cfg_q [NUM_CFG];
  logic        busy_q;
  logic        done_q;

  logic aw_hs, w_hs, ar_hs;
  logic wr_commit;

  logic [ADDR_W-1:0] aw_addr_eff;
  logic [31:0]       w_data_eff;
  logic [3:0]        w_strb_eff;
  logic [31:0]       w_off, r_off;
  reg_dec_t          wr_dec, rd_dec;

  logic [1:0]  wr_resp;
  logic        start_acc;
  logic        cfg_we;
  logic [31:0] rd_data_nxt;
  logic [1:0]  rd_resp_nxt;
  logic        status_clr;

  assign awready = ready_en && (wr_state == WR_IDLE || wr_state == WR_HAVE_W);
  assign wready  = ready_en && (wr_state == WR_IDLE || wr_state == WR_HAVE_AW);
  assign bvalid  = (wr_state == WR_RESP);
  assign arready = ready_en && (rd_state == RD_IDLE);
  assign rvalid  = (rd_state == RD_RESP);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // The write commits on the edge where the second of AW/W is taken, so the
  // beat arriving now is used directly and the earlier one comes from the
  // holding register.
  assign aw_addr_eff = aw_hs ? awaddr : aw_addr_q;
  assign w_data_eff  = w_hs ? wdata[31:0] : w_data_q;
  assign w_strb_eff  = w_hs ? wstrb : w_strb_q;

  always_comb begin
    w_off = '0;
    w_off[ADDR_W-1:0] = aw_addr_eff;
    r_off = '0;
    r_off[ADDR_W-1:0] = araddr;
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
      ready_en <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
      ready_en <= 1'b1;
    end
  end

  // Write FSM next state
  always_comb begin
    wr_state_nxt = wr_state;
    wr_commit    = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_state_nxt = WR_RESP;
          wr_commit    = 1'b1;
        end else if (aw_hs) begin
          wr_state_nxt = WR_HAVE_AW;
        end else if (w_hs) begin
          wr_state_nxt = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        if (w_hs) begin
          wr_state_nxt = WR_RESP;
          wr_commit    = 1'b1;
        end
      end
      WR_HAVE_W: begin
        if (aw_hs) begin
          wr_state_nxt = WR_RESP;
          wr_commit    = 1'b1;
        end
      end
      WR_RESP: begin
        if (bready) wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // Read FSM next state
  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs) rd_state_nxt = RD_RESP;
      RD_RESP: if (rready) rd_state_nxt = RD_IDLE;
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Write decode: response code and side effects of the committing write
  always_comb begin
    wr_dec    = decode_offset(w_off);
    wr_resp   = RESP_SLVERR;
    start_acc = 1'b0;
    cfg_we    = 1'b0;
    case (wr_dec.sel)
      SEL_CTRL: begin
        wr_resp   = RESP_OKAY;
        start_acc = wr_commit && w_strb_eff[0] && w_data_eff[0] && !busy_q;
      end
      SEL_CFG: begin
        if (!busy_q) begin
          wr_resp = RESP_OKAY;
          cfg_we  = wr_commit;
        end
      end
      default: ;
    endcase
  end

  // Read decode
  always_comb begin
    rd_dec      = decode_offset(r_off);
    rd_data_nxt = '0;
    rd_resp_nxt = RESP_OKAY;
    case (rd_dec.sel)
      SEL_CTRL:   rd_data_nxt = '0;
      SEL_STATUS: rd_data_nxt = {30'd0, done_q, busy_q};
      SEL_CFG: begin
        for (int unsigned i = 0; i < NUM_CFG; i++) begin
          if (rd_dec.cfg_idx == 3'(i)) rd_data_nxt = cfg_q[i];
        end
      end
      SEL_ID:     rd_data_nxt = MVM_ID;
      default:    rd_resp_nxt = RESP_SLVERR;
    endcase
  end

  assign status_clr = ar_hs && (rd_dec.sel == SEL_STATUS);

  // Datapath and status
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp     <= RESP_OKAY;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
      start_o   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_CFG; i++) cfg_q[i] <= '0;
    end else begin
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata[31:0];
        w_strb_q <= wstrb;
      end
      if (wr_commit) bresp <= wr_resp;
      start_o <= start_acc;

      for (int unsigned i = 0; i < NUM_CFG; i++) begin
        if (cfg_we && wr_dec.cfg_idx == 3'(i))
          cfg_q[i] <= apply_wstrb(cfg_q[i], w_data_eff, w_strb_eff);
      end

      // Sampled before this edge's write lands, so a same-cycle write is not seen
      if (ar_hs) begin
        rdata <= DATA_W'(rd_data_nxt);
        rresp <= rd_resp_nxt;
      end

      // A fresh start outranks completion; a fresh done outranks the read clear
      if (start_acc)   busy_q <= 1'b1;
      else if (done_i) busy_q <= 1'b0;

      if (done_i)          done_q <= 1'b1;
      else if (status_clr) done_q <= 1'b0;
    end
  end

  assign cfg_dat_in_base_o         = cfg_q[CFG_DAT_IN_BASE];
  assign cfg_dat_in_head_stride_o  = cfg_q[CFG_DAT_IN_HEAD_STRIDE];
  assign cfg_dat_in_line_stride_o  = cfg_q[CFG_DAT_IN_LINE_STRIDE];
  assign cfg_wt_base_o             = cfg_q[CFG_WT_BASE];
  assign cfg_dat_out_base_o        = cfg_q[CFG_DAT_OUT_BASE];
  assign cfg_dat_out_head_stride_o = cfg_q[CFG_DAT_OUT_HEAD_STRIDE];
  assign cfg_dat_out_line_stride_o = cfg_q[CFG_DAT_OUT_LINE_STRIDE];

endmodule

// File: tb/tb_mvm_csr_slave.sv
// tb_mvm_csr_slave
//   Directed AXI4-Lite transactions against mvm_csr_slave. A transaction-level
//   model of the register map tracks expected outputs; a negedge process
//   compares every cycle, and directed reads are also pinned to literals.
module tb_mvm_csr_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        awvalid = 1'b0, awready;
  logic [7:0]  awaddr = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b0;
  logic [1:0]  bresp;
  logic        arvalid = 1'b0, arready;
  logic [7:0]  araddr = '0;
  logic        rvalid, rready = 1'b0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        start_o, done_i = 1'b0;
  logic [31:0] cfg_o [7];

  always #5 clk = ~clk;

  mvm_csr_slave #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .start_o(start_o), .done_i(done_i),
    .cfg_dat_in_base_o(cfg_o[0]),
    .cfg_dat_in_head_stride_o(cfg_o[1]),
    .cfg_dat_in_line_stride_o(cfg_o[2]),
    .cfg_wt_base_o(cfg_o[3]),
    .cfg_dat_out_base_o(cfg_o[4]),
    .cfg_dat_out_head_stride_o(cfg_o[5]),
    .cfg_dat_out_line_stride_o(cfg_o[6])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [31:0] m_cfg [7];
  bit          m_busy, m_done, m_start, m_bvalid, m_rvalid, m_in_reset, started;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] m_rdata;
  bit          m_commit = 0, m_read = 0;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  bit          st_acc, st_clr;
  int unsigned widx, ridx;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      for (int i = 0; i < 7; i++) m_cfg[i] = '0;
      m_busy = 0; m_done = 0; m_start = 0; m_bvalid = 0; m_rvalid = 0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0; m_in_reset = 1;
    end else begin
      m_in_reset = 0;
      st_acc = 0;
      st_clr = 0;
      if (m_bvalid && bready) m_bvalid = 0;
      if (m_rvalid && rready) m_rvalid = 0;
      if (m_read) begin
        ridx = int'(rd_addr) / 4;
        m_rvalid = 1; m_rresp = 2'b00; m_rdata = '0;
        if (ridx == 1) begin
          m_rdata = {30'd0, m_done, m_busy};
          st_clr = 1;
        end else if (ridx >= 2 && ridx <= 8) m_rdata = m_cfg[ridx-2];
        else if (ridx == 9) m_rdata = 32'h4D564D31;
        else if (ridx != 0) m_rresp = 2'b10;
      end
      if (m_commit) begin
        widx = int'(wr_addr) / 4;
        m_bvalid = 1; m_bresp = 2'b10;
        if (widx == 0) begin
          m_bresp = 2'b00;
          st_acc = wr_strb[0] && wr_data[0] && !m_busy;
        end else if (widx >= 2 && widx <= 8 && !m_busy) begin
          m_bresp = 2'b00;
          for (int b = 0; b < 4; b++)
            if (wr_strb[b]) m_cfg[widx-2][8*b +: 8] = wr_data[8*b +: 8];
        end
      end
      m_start = st_acc;
      if (st_acc) m_busy = 1; else if (done_i) m_busy = 0;
      if (done_i) m_done = 1; else if (st_clr) m_done = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 7; i++) check($sformatf("cfg%0d", i), cfg_o[i], m_cfg[i]);
      check("start_o", 32'(start_o), 32'(m_start));
      check("bvalid", 32'(bvalid), 32'(m_bvalid));
      if (m_bvalid) check("bresp", 32'(bresp), 32'(m_bresp));
      check("rvalid", 32'(rvalid), 32'(m_rvalid));
      if (m_rvalid) begin
        check("rdata", rdata, m_rdata);
        check("rresp", 32'(rresp), 32'(m_rresp));
      end
      if (m_in_reset) begin
        check("rst_awready", 32'(awready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_rdata", rdata, 0);
        check("rst_bresp", 32'(bresp), 0);
        check("rst_rresp", 32'(rresp), 0);
      end
    end
  end

  // ---------------- transaction tasks (start/end at posedge+1) ----------------
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_delay, input int w_delay,
                           input int b_delay, input bit done_at_commit,
                           output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs, got;
    int cyc = 0;
    resp = 2'b11;
    wr_addr = addr; wr_data = data; wr_strb = strb;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (cyc >= aw_delay); awaddr = addr;
      wvalid  = !w_done && (cyc >= w_delay);   wdata = data; wstrb = strb;
      @(negedge clk);
      if (aw_done) check("awready_held_low", 32'(awready), 0);
      if (w_done)  check("wready_held_low", 32'(wready), 0);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if ((aw_hs || aw_done) && (w_hs || w_done)) begin
        m_commit = 1;
        if (done_at_commit) done_i = 1;
      end
      @(posedge clk); #1;
      m_commit = 0;
      if (done_at_commit) done_i = 0;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      cyc++;
      if (cyc > 50) begin
        check("write_handshake_timeout", 0, 1);
        break;
      end
    end
    awvalid = 0; wvalid = 0;
    if (b_delay < 0) return;
    for (int i = 0; i < b_delay; i++) begin
      @(negedge clk);
      check("awready_during_b", 32'(awready), 0);
      check("wready_during_b", 32'(wready), 0);
      @(posedge clk); #1;
    end
    bready = 1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = bvalid;
      resp = bresp;
      @(posedge clk); #1;
    end
    bready = 0;
    if (!got) check("bvalid_timeout", 0, 1);
  endtask

  task automatic axi_read(input logic [7:0] addr, input int r_delay, input bit done_at_hs,
                          output logic [31:0] data, output logic [1:0] resp);
    bit hs = 0, got = 0;
    int cyc = 0;
    data = 'x; resp = 2'b11;
    arvalid = 1; araddr = addr; rd_addr = addr;
    while (!hs) begin
      @(negedge clk);
      hs = arready;
      if (hs) begin
        m_read = 1;
        if (done_at_hs) done_i = 1;
      end
      @(posedge clk); #1;
      m_read = 0;
      if (done_at_hs) done_i = 0;
      cyc++;
      if (cyc > 50) begin
        check("read_handshake_timeout", 0, 1);
        break;
      end
    end
    arvalid = 0;
    for (int i = 0; i < r_delay; i++) begin
      @(posedge clk); #1;
    end
    rready = 1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = rvalid;
      data = rdata;
      resp = rresp;
      @(posedge clk); #1;
    end
    rready = 0;
    if (!got) check("rvalid_timeout", 0, 1);
  endtask

  task automatic done_pulse();
    done_i = 1;
    @(posedge clk); #1;
    done_i = 0;
  endtask

  task automatic wr_chk(input string name, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] r;
    axi_write(addr, data, strb, 0, 0, 0, 0, r);
    check(name, 32'(r), 32'(exp_resp));
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input int r_delay,
                        input bit done_at_hs, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, r_delay, done_at_hs, d, r);
    check({name, "_data"}, d, exp_data);
    check({name, "_resp"}, 32'(r), 32'(exp_resp));
  endtask

  // ---------------- directed stimulus ----------------
  logic [1:0]  wr_r, rd_r;
  logic [31:0] rd_d;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("ready_before_release_edge", 32'({awready, wready, arready}), 0);
    @(negedge clk);
    check("ready_after_release", 32'({awready, wready, arready}), 32'h7);
    @(posedge clk); #1;

    // AW two cycles before W
    axi_write(8'h08, 32'h0200_0000, 4'hF, 0, 2, 0, 0, wr_r);
    check("din_base_bresp", 32'(wr_r), 0);
    check("din_base_cfg", cfg_o[0], 32'h0200_0000);
    rd_chk("din_base_rd", 8'h08, 0, 0, 32'h0200_0000, 2'b00);

    // Partial strobe over zero
    wr_chk("head_stride_wr", 8'h0C, 32'hFFFF_FFFF, 4'b0101, 2'b00);
    rd_chk("head_stride_rd", 8'h0C, 0, 0, 32'h00FF_00FF, 2'b00);

    // W ahead of AW, then same cycle with a slow bready
    axi_write(8'h10, 32'h1234_5678, 4'hF, 3, 0, 0, 0, wr_r);
    check("w_first_bresp", 32'(wr_r), 0);
    axi_write(8'h14, 32'hA5A5_5A5A, 4'hF, 0, 0, 3, 0, wr_r);
    check("slow_b_bresp", 32'(wr_r), 0);
    rd_chk("low_bits_ignored", 8'h16, 0, 0, 32'hA5A5_5A5A, 2'b00);
    wr_chk("top_lane_wr", 8'h10, 32'hDEAD_BEEF, 4'b1000, 2'b00);
    rd_chk("top_lane_rd", 8'h10, 0, 0, 32'hDE34_5678, 2'b00);

    // Error responses and constant registers
    wr_chk("wr_status_err", 8'h04, 32'h3, 4'hF, 2'b10);
    wr_chk("wr_id_err", 8'h24, 32'h0, 4'hF, 2'b10);
    wr_chk("wr_unmapped_28", 8'h28, 32'h1, 4'hF, 2'b10);
    wr_chk("wr_unmapped_fc", 8'hFC, 32'h1, 4'hF, 2'b10);
    rd_chk("rd_unmapped", 8'h40, 0, 0, 32'h0, 2'b10);
    rd_chk("rd_id_slow", 8'h24, 5, 0, 32'h4D56_4D31, 2'b00);
    rd_chk("rd_ctrl", 8'h00, 0, 0, 32'h0, 2'b00);

    // Start, busy-time write, done
    wr_chk("start_wr", 8'h00, 32'h1, 4'hF, 2'b00);
    rd_chk("status_busy", 8'h04, 0, 0, 32'h1, 2'b00);
    wr_chk("cfg_wr_busy", 8'h18, 32'h1111_1111, 4'hF, 2'b10);
    rd_chk("cfg_unchanged", 8'h18, 0, 0, 32'h0, 2'b00);
    wr_chk("start_while_busy", 8'h00, 32'h1, 4'hF, 2'b00);
    done_pulse();
    rd_chk("status_done", 8'h04, 0, 0, 32'h2, 2'b00);
    rd_chk("status_cleared", 8'h04, 0, 0, 32'h0, 2'b00);

    // Start bit with its lane strobe off does nothing
    wr_chk("start_no_strb", 8'h00, 32'h1, 4'b1110, 2'b00);
    rd_chk("status_idle", 8'h04, 0, 0, 32'h0, 2'b00);

    // Start accepted on the same edge as done_i
    axi_write(8'h00, 32'h1, 4'h1, 0, 0, 0, 1, wr_r);
    check("start_done_bresp", 32'(wr_r), 0);
    rd_chk("start_done_status", 8'h04, 0, 0, 32'h3, 2'b00);
    rd_chk("start_done_status2", 8'h04, 0, 0, 32'h1, 2'b00);
    done_pulse();
    rd_chk("final_done", 8'h04, 0, 0, 32'h2, 2'b00);

    // STATUS read coincident with done_i
    rd_chk("coinc_pre0", 8'h04, 0, 1, 32'h0, 2'b00);
    rd_chk("coinc_after0", 8'h04, 0, 0, 32'h2, 2'b00);
    rd_chk("coinc_clear0", 8'h04, 0, 0, 32'h0, 2'b00);
    done_pulse();
    rd_chk("coinc_pre1", 8'h04, 0, 1, 32'h2, 2'b00);
    rd_chk("coinc_after1", 8'h04, 0, 0, 32'h2, 2'b00);
    rd_chk("coinc_clear1", 8'h04, 0, 0, 32'h0, 2'b00);

    // Read and write of the same register on the same edge
    wr_chk("line_stride_init", 8'h20, 32'h0000_0020, 4'hF, 2'b00);
    fork
      axi_write(8'h20, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 0, wr_r);
      axi_read(8'h20, 0, 0, rd_d, rd_r);
    join
    check("concurrent_bresp", 32'(wr_r), 0);
    check("concurrent_old_value", rd_d, 32'h0000_0020);
    rd_chk("concurrent_new_value", 8'h20, 0, 0, 32'hCAFE_F00D, 2'b00);

    // Reset with a write response outstanding
    axi_write(8'h1C, 32'h0000_0077, 4'hF, 0, 0, -1, 0, wr_r);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("rst_drops_bvalid", 32'(bvalid), 0);
    check("rst_clears_cfg", cfg_o[5] | cfg_o[0] | cfg_o[6], 0);
    @(negedge clk);
    check("ready_after_rst", 32'({awready, wready, arready}), 32'h7);
    @(posedge clk); #1;
    rd_chk("cfg_after_rst", 8'h08, 0, 0, 32'h0, 2'b00);
    rd_chk("status_after_rst", 8'h04, 0, 0, 32'h0, 2'b00);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
